dma_bus_master: RTL

//  Single-channel GBA-style DMA engine: the initiator on the clk_mem memory/IO bus that io_register and other responders serve.
//  On a start strobe it copies COUNT halfwords/words from a source to a destination, one read access then one write access per unit.

---
 rtl/dma_bus_master_if.sv | 23 ++
 rtl/dma_bus_master.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dma_bus_master_if.sv
// Memory/IO bus between the DMA initiator and its responder/arbiter.
// One access in flight at a time; the responder completes it by raising bus_ready.
interface dma_bus_master_if #(
  parameter int ADDR_W = 28
);
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_read;
  logic              bus_write;
  logic [1:0]        bus_width;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ready;

  modport master (
    output bus_addr, bus_read, bus_write, bus_width, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_addr, bus_read, bus_write, bus_width, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/dma_bus_master.sv
// Single-channel DMA engine: copies COUNT halfwords/words, one read then one write per unit,
// and pulses done_irq once the last write has been accepted.
module dma_bus_master #(
  parameter int ADDR_W = 28,
  parameter int CNT_W  = 14
) (
  input  logic              clk_mem,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [1:0]        cfg_src_ctl,
  input  logic [1:0]        cfg_dst_ctl,
  input  logic              cfg_word,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done_irq,
  dma_bus_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  localparam logic [CNT_W:0] REM_ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] REM_FULL = {1'b1, {CNT_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [CNT_W:0]    rem_q, rem_d;
  logic [31:0]       data_q, data_d;
  logic              word_q, word_d;
  logic [1:0]        sctl_q, sctl_d, dctl_q, dctl_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [1:0]        width_q, width_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  // Plain ADDR_W-bit arithmetic gives the required wrap in both directions.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic inc, input logic dec,
                                                  input logic word);
    logic [ADDR_W-1:0] d;
    d = word ? ADDR_W'(4) : ADDR_W'(2);
    if (inc)      return a + d;
    else if (dec) return a - d;
    else          return a;
  endfunction

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    word_d  = word_q;
    sctl_d  = sctl_q;
    dctl_d  = dctl_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          word_d  = cfg_word;
          sctl_d  = cfg_src_ctl;
          dctl_d  = cfg_dst_ctl;
          src_d   = cfg_src & ~(cfg_word ? ADDR_W'(3) : ADDR_W'(1));
          dst_d   = cfg_dst & ~(cfg_word ? ADDR_W'(3) : ADDR_W'(1));
          rem_d   = (cfg_count == '0) ? REM_FULL : {1'b0, cfg_count};
          state_d = READ;
        end
      end
      READ: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bus.bus_ready) begin
          data_d  = word_q ? bus.bus_rdata : {bus.bus_rdata[15:0], bus.bus_rdata[15:0]};
          state_d = WRITE;
        end
      end
      WRITE: begin
        // An accepted write is committed even when abort arrives in the same cycle.
        if (bus.bus_ready) begin
          src_d   = step_addr(src_q, sctl_q == 2'b00, sctl_q == 2'b01, word_q);
          dst_d   = step_addr(dst_q, dctl_q == 2'b00 || dctl_q == 2'b11,
                              dctl_q == 2'b01, word_q);
          rem_d   = rem_q - REM_ONE;
          state_d = abort ? IDLE : ((rem_q == REM_ONE) ? DONE : READ);
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are the registered image of the next state.
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    rd_d    = (state_d == READ);
    wr_d    = (state_d == WRITE);
    width_d = (rd_d || wr_d) ? (word_d ? 2'b10 : 2'b01) : 2'b00;
    addr_d  = rd_d ? src_d : (wr_d ? dst_d : '0);
    wdata_d = wr_d ? data_d : 32'h0;
  end

  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      word_q  <= 1'b0;
      sctl_q  <= 2'b00;
      dctl_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      width_q <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      word_q  <= word_d;
      sctl_q  <= sctl_d;
      dctl_q  <= dctl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      width_q <= width_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done_irq      = done_q;
  assign bus.bus_read  = rd_q;
  assign bus.bus_write = wr_q;
  assign bus.bus_width = width_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

endmodule
